// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state types and data-width clamp helper for uart_core
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } uart_tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } uart_rx_state_t;

    localparam int UART_MIN_DATA_BITS = 5;

    function automatic logic [3:0] uart_clamp_bits(input logic [3:0] bits, input int unsigned max_bits);
        logic [31:0] b;
        b = {28'd0, bits};
        if (b < 32'(UART_MIN_DATA_BITS) || b > 32'(max_bits))
            return 4'(max_bits);
        return bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversample tick generator, one tick every div+1 clocks
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // A new divisor is only picked up at reload, so the running period never tears.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!en || cnt == '0)
            cnt <= div;
        else
            cnt <= cnt - 1'b1;
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART engine; UART_RX_MAJORITY_EN selects 2-of-3 RX sampling
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_two_stop,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              tx_busy,
    output logic              rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVS - 1);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVS / 2 - 1);

    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [3:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (4'(i) < n) p = p ^ d[i];
        return p;
    endfunction

    logic       tick;
    logic [3:0] cfg_nbits;

    assign cfg_nbits = uart_clamp_bits(cfg_data_bits, DATA_W);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clock (clock),
        .reset (reset),
        .en    (cfg_en),
        .div   (cfg_div),
        .tick  (tick)
    );

    uart_tx_state_t    tx_state, tx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [3:0]        tx_nbits, tx_bit_cnt;
    logic [TW-1:0]     tx_tick_cnt;
    logic              tx_par_en, tx_par_bit, tx_two_stop, tx_stop_cnt;
    logic              tx_fire, tx_bit_done;

    assign tx_ready    = (tx_state == TX_IDLE) && cfg_en;
    assign tx_fire     = tx_valid && tx_ready;
    assign tx_bit_done = tick && (tx_tick_cnt == LAST_TICK);
    assign tx_busy     = (tx_state != TX_IDLE);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_fire) tx_next = TX_START;
            TX_START:  if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_done && tx_bit_cnt == tx_nbits - 4'd1)
                           tx_next = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_done) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_done && tx_stop_cnt == tx_two_stop) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
        if (!cfg_en) tx_next = TX_IDLE;
    end

    // Decoded straight from state so an async reset releases the line at once.
    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shift[0];
            TX_PARITY: txd = tx_par_bit;
            default:   txd = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_nbits    <= '0;
            tx_bit_cnt  <= '0;
            tx_tick_cnt <= '0;
            tx_par_en   <= 1'b0;
            tx_par_bit  <= 1'b0;
            tx_two_stop <= 1'b0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_fire) begin
                tx_shift    <= tx_data;
                tx_nbits    <= cfg_nbits;
                tx_par_en   <= cfg_parity_en;
                tx_par_bit  <= parity_of(tx_data, cfg_nbits) ^ cfg_parity_odd;
                tx_two_stop <= cfg_two_stop;
                tx_bit_cnt  <= '0;
                tx_stop_cnt <= 1'b0;
                tx_tick_cnt <= '0;
            end else if (tick && tx_state != TX_IDLE) begin
                tx_tick_cnt <= tx_bit_done ? '0 : tx_tick_cnt + TW'(1);
                if (tx_bit_done && tx_state == TX_DATA) begin
                    tx_shift   <= tx_shift >> 1;
                    tx_bit_cnt <= tx_bit_cnt + 4'd1;
                end
                if (tx_bit_done && tx_state == TX_STOP)
                    tx_stop_cnt <= 1'b1;
            end
        end
    end

    uart_rx_state_t    rx_state, rx_next;
    logic [1:0]        rx_sync;
    logic              rx_s, rx_prev, rx_bit, rx_sample, rx_start;
    logic [TW-1:0]     rx_tick_cnt;
    logic [DATA_W-1:0] rx_shift;
    logic [3:0]        rx_nbits, rx_bit_cnt;
    logic              rx_par_en, rx_par_acc, rx_perr;

    assign rx_s    = rx_sync[1];
    assign rx_busy = (rx_state != RX_IDLE);

`ifdef UART_RX_MAJORITY_EN
    logic rx_m0, rx_m1;
    assign rx_sample = tick && (rx_tick_cnt == TW'(OVS / 2));
    assign rx_bit    = (rx_m0 & rx_m1) | (rx_m0 & rx_s) | (rx_m1 & rx_s);
`else
    assign rx_sample = tick && (rx_tick_cnt == MID_TICK);
    assign rx_bit    = rx_s;
`endif

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (cfg_en && rx_prev && !rx_s) rx_next = RX_START;
            RX_START:  if (rx_sample) rx_next = rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit_cnt == rx_nbits - 4'd1)
                           rx_next = rx_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
        if (!cfg_en) rx_next = RX_IDLE;
    end

    assign rx_start = (rx_state == RX_IDLE) && (rx_next == RX_START);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state      <= RX_IDLE;
            rx_sync       <= 2'b11;
            rx_prev       <= 1'b1;
            rx_tick_cnt   <= '0;
            rx_shift      <= '0;
            rx_nbits      <= '0;
            rx_bit_cnt    <= '0;
            rx_par_en     <= 1'b0;
            rx_par_acc    <= 1'b0;
            rx_perr       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            rx_m0         <= 1'b1;
            rx_m1         <= 1'b1;
`endif
        end else begin
            rx_state <= rx_next;
            rx_sync  <= {rx_sync[0], rxd};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            if (rx_start) begin
                rx_tick_cnt <= '0;
                rx_shift    <= '0;
                rx_bit_cnt  <= '0;
                rx_nbits    <= cfg_nbits;
                rx_par_en   <= cfg_parity_en;
                rx_par_acc  <= cfg_parity_odd;
                rx_perr     <= 1'b0;
            end else if (tick && rx_state != RX_IDLE) begin
                rx_tick_cnt <= (rx_tick_cnt == LAST_TICK) ? '0 : rx_tick_cnt + TW'(1);
`ifdef UART_RX_MAJORITY_EN
                if (rx_tick_cnt == TW'(OVS / 2 - 2)) rx_m0 <= rx_s;
                if (rx_tick_cnt == MID_TICK) rx_m1 <= rx_s;
`endif
                if (rx_sample) begin
                    case (rx_state)
                        RX_DATA: begin
                            for (int i = 0; i < DATA_W; i++)
                                if (4'(i) == rx_bit_cnt) rx_shift[i] <= rx_bit;
                            rx_par_acc <= rx_par_acc ^ rx_bit;
                            rx_bit_cnt <= rx_bit_cnt + 4'd1;
                        end
                        RX_PARITY: rx_perr <= rx_bit ^ rx_par_acc;
                        RX_STOP: begin
                            rx_valid      <= cfg_en;
                            rx_data       <= rx_shift;
                            rx_parity_err <= rx_perr;
                            rx_frame_err  <= !rx_bit;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - directed self-checking bench for uart_core (bit time = 64 clocks)
module tb_uart_core;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_en, cfg_parity_en, cfg_parity_odd, cfg_two_stop;
    logic [15:0] cfg_div;
    logic [3:0] cfg_data_bits;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, txd, rxd, rx_valid, rx_parity_err, rx_frame_err;
    logic       tx_busy, rx_busy;
    logic       rxd_drv, loopback;

    assign rxd = loopback ? txd : rxd_drv;

    uart_core #(.DATA_W(8), .OVS(16), .DIV_W(16)) dut (
        .clock(clock), .reset(reset), .cfg_en(cfg_en), .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd),
        .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .tx_busy(tx_busy), .rx_busy(rx_busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int         rx_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    logic       perr_last = 1'b0, ferr_last = 1'b0;

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_last   = rx_data;
            perr_last = rx_parity_err;
            ferr_last = rx_frame_err;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic [3:0] cfg_bits;
        int         sent_bits;
        bit         pe, po, ts, flip, stop_low;
        logic [7:0] exp_data;
        bit         exp_perr, exp_ferr;
    } vec_t;

    vec_t vecs[9];

    task automatic send_bit(input logic b);
        rxd_drv = b;
        repeat (64) @(negedge clock);
    endtask

    task automatic drive_frame(input vec_t v);
        logic p;
        p = v.po;
        send_bit(1'b0);
        for (int i = 0; i < v.sent_bits; i++) begin
            send_bit(v.data[i]);
            p = p ^ v.data[i];
        end
        if (v.pe) send_bit(p ^ v.flip);
        send_bit(!v.stop_low);
        if (v.ts) send_bit(1'b1);
        rxd_drv = 1'b1;
        repeat (20) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, k, c0;
        logic [9:0] exp_bits;

        reset = 1'b0; cfg_en = 1'b0; cfg_div = 16'd3; cfg_data_bits = 4'd8;
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; rxd_drv = 1'b1; loopback = 1'b0;

        vecs[0] = '{8'h3C, 4'd8,  8, 1, 1, 0, 1, 0, 8'h3C, 1, 0};
        vecs[1] = '{8'h00, 4'd8,  8, 0, 0, 0, 0, 1, 8'h00, 0, 1};
        vecs[2] = '{8'h81, 4'd8,  8, 0, 0, 0, 0, 0, 8'h81, 0, 0};
        vecs[3] = '{8'h1F, 4'd5,  5, 1, 0, 0, 0, 0, 8'h1F, 0, 0};
        vecs[4] = '{8'hFF, 4'd5,  5, 0, 0, 0, 0, 0, 8'h1F, 0, 0};
        vecs[5] = '{8'hA7, 4'd3,  8, 0, 0, 0, 0, 0, 8'hA7, 0, 0};
        vecs[6] = '{8'h96, 4'd8,  8, 1, 0, 1, 0, 0, 8'h96, 0, 0};
        vecs[7] = '{8'h6B, 4'd15, 8, 1, 1, 0, 0, 0, 8'h6B, 0, 0};
        vecs[8] = '{8'h2D, 4'd6,  6, 1, 1, 0, 1, 0, 8'h2D, 1, 0};

        repeat (3) @(negedge clock);
        check("rst_txd", txd, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_perr", rx_parity_err, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // 8N1 0xA5, enable and request raised together so the baud phase is known
        exp_bits = {1'b1, 8'hA5, 1'b0};
        cfg_en = 1'b1; tx_data = 8'hA5; tx_valid = 1'b1;
        #1 check("tx_ready_idle", tx_ready, 1);
        idx = 0; k = 0;
        while (!(idx > 0 && tx_ready) && idx < 800) begin
            @(negedge clock);
            idx++;
            if (idx == 1) tx_valid = 1'b0;
            if (k < 10 && idx == 33 + 64 * k) begin
                check($sformatf("tx_bit%0d", k), txd, exp_bits[k]);
                if (k == 4) check("tx_busy_mid", tx_busy, 1);
                k++;
            end
        end
        check("tx_ready_return", idx, 640);
        check("tx_bits_seen", k, 10);

        // loopback 7E2 0x55
        repeat (5) @(negedge clock);
        loopback = 1'b1; cfg_data_bits = 4'd7; cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b0; cfg_two_stop = 1'b1;
        c0 = rx_cnt;
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        idx = 0;
        while (!tx_ready && idx < 1000) begin
            @(negedge clock);
            idx++;
        end
        repeat (10) @(negedge clock);
        check("lb_done", idx < 1000, 1);
        check("lb_count", rx_cnt - c0, 1);
        check("lb_data", rx_last, 8'h55);
        check("lb_perr", perr_last, 0);
        check("lb_ferr", ferr_last, 0);
        loopback = 1'b0;
        repeat (10) @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            cfg_data_bits  = vecs[i].cfg_bits;
            cfg_parity_en  = vecs[i].pe;
            cfg_parity_odd = vecs[i].po;
            cfg_two_stop   = vecs[i].ts;
            c0 = rx_cnt;
            drive_frame(vecs[i]);
            check($sformatf("v%0d_count", i), rx_cnt - c0, 1);
            check($sformatf("v%0d_data", i), rx_last, vecs[i].exp_data);
            check($sformatf("v%0d_perr", i), perr_last, vecs[i].exp_perr);
            check($sformatf("v%0d_ferr", i), ferr_last, vecs[i].exp_ferr);
        end

        // 0.3-bit low pulse must be rejected as a false start
        cfg_data_bits = 4'd8; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
        c0 = rx_cnt;
        rxd_drv = 1'b0;
        repeat (10) @(negedge clock);
        check("glitch_busy", rx_busy, 1);
        repeat (9) @(negedge clock);
        rxd_drv = 1'b1;
        repeat (29) @(negedge clock);
        check("glitch_idle", rx_busy, 0);
        repeat (100) @(negedge clock);
        check("glitch_no_valid", rx_cnt - c0, 0);

        // cfg_en dropped mid-frame
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (200) @(negedge clock);
        check("abort_pre_txd", txd, 0);
        check("abort_pre_busy", tx_busy, 1);
        cfg_en = 1'b0;
        @(negedge clock);
        check("abort_txd", txd, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_ready", tx_ready, 0);
        cfg_en = 1'b1;
        repeat (5) @(negedge clock);

        // asynchronous reset mid-frame
        tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        repeat (100) @(negedge clock);
        check("areset_pre_txd", txd, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check("areset_txd", txd, 1);
        check("areset_busy", tx_busy, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);

`ifdef UART_RX_MAJORITY_EN
        begin
            logic [7:0] d;
            d = 8'hF0;
            c0 = rx_cnt;
            send_bit(1'b0);
            for (int i = 0; i < 8; i++) begin
                if (i == 3) begin
                    rxd_drv = 1'b0;
                    repeat (32) @(negedge clock);
                    rxd_drv = 1'b1;
                    @(negedge clock);
                    rxd_drv = 1'b0;
                    repeat (31) @(negedge clock);
                end else begin
                    send_bit(d[i]);
                end
            end
            send_bit(1'b1);
            repeat (20) @(negedge clock);
            check("maj_count", rx_cnt - c0, 1);
            check("maj_data", rx_last, 8'hF0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
